// File: rtl/bpred_resolve_unit.sv
// bpred_resolve_unit: in-order in-flight branch FIFO that resolves predictions and drives predictor feedback/redirect.
// Optional BPRED_STATS_EN adds saturating branch/mispredict counters.
module bpred_resolve_unit #(
  parameter  int NUM_ENTRIES = 1024,
  parameter  int FIFO_DEPTH  = 4,
  localparam int IW          = $clog2(NUM_ENTRIES),
  localparam int PW          = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pred_valid_i,
  input  logic [IW-1:0] pred_idx_i,
  input  logic          pred_taken_i,
  input  logic [31:0]   pred_target_i,
  output logic          pred_ready_o,
  input  logic          res_valid_i,
  input  logic          res_taken_i,
  input  logic [31:0]   res_target_i,
  input  logic [31:0]   res_fallthru_i,
  output logic          brn_ex_mem_bpred_o,
  output logic [IW-1:0] brn_fdback_addr_bpred_o,
  output logic          brn_fdback_bpred_o,
  output logic [31:0]   brn_btb_addr_bpred_o,
  output logic          brn_btb_wr_bpred_o,
  output logic          redirect_valid_o,
  output logic [31:0]   redirect_pc_o,
  output logic          flush_o,
  output logic          underflow_o
`ifdef BPRED_STATS_EN
  ,
  output logic [31:0]   stat_branches_o,
  output logic [31:0]   stat_mispred_o
`endif
);
  logic [IW-1:0] idx_mem [FIFO_DEPTH];
  logic          tkn_mem [FIFO_DEPTH];
  logic [31:0]   tgt_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          pop, push, mis, tgt_diff, btb_wr;
  logic          ex_mem_q, fdback_q, btb_wr_q, redir_q, flush_q, undf_q;
  logic [IW-1:0] addr_q;
  logic [31:0]   btb_addr_q, redir_pc_q;

  assign pred_ready_o = cnt_q != (PW+1)'(FIFO_DEPTH);
  assign pop          = res_valid_i & (cnt_q != '0);
  assign tgt_diff     = tgt_mem[rd_q] != res_target_i;
  assign mis          = pop & ((tkn_mem[rd_q] != res_taken_i) | (res_taken_i & tkn_mem[rd_q] & tgt_diff));
  assign push         = pred_valid_i & pred_ready_o & !mis;
  assign btb_wr       = res_taken_i & (!tkn_mem[rd_q] | tgt_diff);

  // A mispredict squashes every record, including a same-cycle wrong-path push.
  always_comb begin
    rd_d  = mis ? '0 : rd_q + PW'(pop);
    wr_d  = mis ? '0 : wr_q + PW'(push);
    cnt_d = mis ? '0 : cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[wr_q] <= pred_idx_i;
      tkn_mem[wr_q] <= pred_taken_i;
      tgt_mem[wr_q] <= pred_target_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      ex_mem_q   <= 1'b0;
      fdback_q   <= 1'b0;
      btb_wr_q   <= 1'b0;
      redir_q    <= 1'b0;
      flush_q    <= 1'b0;
      undf_q     <= 1'b0;
      addr_q     <= '0;
      btb_addr_q <= '0;
      redir_pc_q <= '0;
    end else begin
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      ex_mem_q <= pop;
      btb_wr_q <= pop & btb_wr;
      redir_q  <= mis;
      flush_q  <= mis;
      undf_q   <= undf_q | (res_valid_i & (cnt_q == '0));
      if (pop) begin
        addr_q     <= idx_mem[rd_q];
        fdback_q   <= res_taken_i;
        btb_addr_q <= res_target_i;
        redir_pc_q <= res_taken_i ? res_target_i : res_fallthru_i;
      end
    end
  end

  assign brn_ex_mem_bpred_o      = ex_mem_q;
  assign brn_fdback_addr_bpred_o = addr_q;
  assign brn_fdback_bpred_o      = fdback_q;
  assign brn_btb_addr_bpred_o    = btb_addr_q;
  assign brn_btb_wr_bpred_o      = btb_wr_q;
  assign redirect_valid_o        = redir_q;
  assign redirect_pc_o           = redir_pc_q;
  assign flush_o                 = flush_q;
  assign underflow_o             = undf_q;

`ifdef BPRED_STATS_EN
  logic [31:0] br_q, mp_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      br_q <= (pop && br_q != '1) ? br_q + 32'd1 : br_q;
      mp_q <= (mis && mp_q != '1) ? mp_q + 32'd1 : mp_q;
    end
  end
  assign stat_branches_o = br_q;
  assign stat_mispred_o  = mp_q;
`endif
endmodule

// File: tb/tb_bpred_resolve_unit.sv
// tb_bpred_resolve_unit: directed self-checking bench for bpred_resolve_unit.
module tb_bpred_resolve_unit;
  localparam int IW = 10;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pred_valid_i = 1'b0, pred_taken_i = 1'b0, pred_ready_o;
  logic [IW-1:0] pred_idx_i = '0;
  logic [31:0]   pred_target_i = '0;
  logic          res_valid_i = 1'b0, res_taken_i = 1'b0;
  logic [31:0]   res_target_i = '0, res_fallthru_i = '0;
  logic          ex_mem, fdback, btb_wr, redir, flush, undf;
  logic [IW-1:0] fd_addr;
  logic [31:0]   btb_addr, redir_pc;
`ifdef BPRED_STATS_EN
  logic [31:0]   st_br, st_mp;
`endif
  int checks = 0, failures = 0;

  bpred_resolve_unit dut (
    .clk(clk), .reset(reset),
    .pred_valid_i(pred_valid_i), .pred_idx_i(pred_idx_i), .pred_taken_i(pred_taken_i),
    .pred_target_i(pred_target_i), .pred_ready_o(pred_ready_o),
    .res_valid_i(res_valid_i), .res_taken_i(res_taken_i), .res_target_i(res_target_i),
    .res_fallthru_i(res_fallthru_i),
    .brn_ex_mem_bpred_o(ex_mem), .brn_fdback_addr_bpred_o(fd_addr), .brn_fdback_bpred_o(fdback),
    .brn_btb_addr_bpred_o(btb_addr), .brn_btb_wr_bpred_o(btb_wr),
    .redirect_valid_o(redir), .redirect_pc_o(redir_pc), .flush_o(flush), .underflow_o(undf)
`ifdef BPRED_STATS_EN
    , .stat_branches_o(st_br), .stat_mispred_o(st_mp)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic tkn, input logic [31:0] tgt);
    pred_valid_i = 1'b1; pred_idx_i = IW'(idx); pred_taken_i = tkn; pred_target_i = tgt;
  endtask

  task automatic res(input logic tkn, input logic [31:0] tgt, input logic [31:0] ft);
    res_valid_i = 1'b1; res_taken_i = tkn; res_target_i = tgt; res_fallthru_i = ft;
  endtask

  task automatic idle();
    pred_valid_i = 1'b0; res_valid_i = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_ex_mem", 32'(ex_mem), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_redir_pc", redir_pc, 0);
    chk("rst_underflow", 32'(undf), 0);
    chk("rst_ready", 32'(pred_ready_o), 1);
    reset = 1'b1;
    tick();
    // 1: correct taken prediction
    push(5, 1, 32'h100); tick(); idle();
    res(1, 32'h100, 32'h8); tick(); idle();
    chk("t1_ex_mem", 32'(ex_mem), 1);
    chk("t1_addr", 32'(fd_addr), 5);
    chk("t1_fdback", 32'(fdback), 1);
    chk("t1_btb_wr", 32'(btb_wr), 0);
    chk("t1_redir", 32'(redir), 0);
    chk("t1_flush", 32'(flush), 0);
    tick();
    chk("t1_ex_mem_pulse", 32'(ex_mem), 0);
    // 2: predicted not-taken, actually taken
    push(9, 0, 32'h0); tick(); idle();
    res(1, 32'h200, 32'h44); tick(); idle();
    chk("t2_addr", 32'(fd_addr), 9);
    chk("t2_btb_wr", 32'(btb_wr), 1);
    chk("t2_btb_addr", btb_addr, 32'h200);
    chk("t2_redir_pc", redir_pc, 32'h200);
    chk("t2_flush", 32'(flush), 1);
    chk("t2_redir", 32'(redir), 1);
    tick();
    chk("t2_flush_pulse", 32'(flush), 0);
    chk("t2_redir_pc_hold", redir_pc, 32'h200);
    // 3: predicted taken, actually not-taken
    push(3, 1, 32'h300); tick(); idle();
    res(0, 32'h0, 32'h3C); tick(); idle();
    chk("t3_fdback", 32'(fdback), 0);
    chk("t3_btb_wr", 32'(btb_wr), 0);
    chk("t3_redir_pc", redir_pc, 32'h3C);
    chk("t3_flush", 32'(flush), 1);
    // 4: fill to full, drop a fifth push, drain in order
    for (int i = 0; i < 4; i++) begin
      chk("t4_ready_before_full", 32'(pred_ready_o), 1);
      push(10 + i, 0, 32'h0); tick();
    end
    chk("t4_ready_full", 32'(pred_ready_o), 0);
    push(14, 0, 32'h0); tick(); idle();
    chk("t4_ready_still_full", 32'(pred_ready_o), 0);
    for (int i = 0; i < 4; i++) begin
      res(0, 32'h0, 32'h80); tick();
      chk("t4_ex_mem", 32'(ex_mem), 1);
      chk("t4_addr", 32'(fd_addr), 10 + i);
      chk("t4_flush", 32'(flush), 0);
    end
    idle(); tick();
    chk("t4_ex_mem_idle", 32'(ex_mem), 0);
    chk("t4_ready_empty", 32'(pred_ready_o), 1);
    // 5: wrap with simultaneous push/pop, then mispredict with wrong-path push
    for (int i = 0; i < 4; i++) begin push(20 + i, 0, 32'h0); tick(); end
    idle(); res(0, 32'h0, 32'h90); tick();
    chk("t5_addr20", 32'(fd_addr), 20);
    chk("t5_ready_after_pop", 32'(pred_ready_o), 1);
    push(7, 0, 32'h0); tick(); idle();
    chk("t5_addr21", 32'(fd_addr), 21);
    chk("t5_ready_pushpop", 32'(pred_ready_o), 1);
    for (int i = 0; i < 3; i++) begin
      res(0, 32'h0, 32'h90); tick();
      chk("t5_drain_addr", 32'(fd_addr), (i == 2) ? 7 : 22 + i);
      chk("t5_drain_flush", 32'(flush), 0);
    end
    idle();
    push(30, 0, 32'h0); tick(); idle();
    res(1, 32'h500, 32'h94); push(31, 0, 32'h0); tick(); idle();
    chk("t5_mis_flush", 32'(flush), 1);
    chk("t5_mis_addr", 32'(fd_addr), 30);
    chk("t5_mis_pc", redir_pc, 32'h500);
    chk("t5_ready_cleared", 32'(pred_ready_o), 1);
    chk("t5_no_underflow_yet", 32'(undf), 0);
    // 6: discarded record leaves the FIFO empty -> underflow
    res(1, 32'h500, 32'h94); tick(); idle();
    chk("t6_undf", 32'(undf), 1);
    chk("t6_no_ex_mem", 32'(ex_mem), 0);
    tick();
    chk("t6_undf_sticky", 32'(undf), 1);
`ifdef BPRED_STATS_EN
    chk("stat_branches", st_br, 13);
    chk("stat_mispred", st_mp, 3);
`endif
    // reset with two records pending
    push(40, 1, 32'h600); tick(); push(41, 1, 32'h700); tick(); idle();
    #2 reset = 1'b0; #1;
    chk("rst2_undf", 32'(undf), 0);
    chk("rst2_redir_pc", redir_pc, 0);
    chk("rst2_addr", 32'(fd_addr), 0);
`ifdef BPRED_STATS_EN
    chk("rst2_stat_br", st_br, 0);
    chk("rst2_stat_mp", st_mp, 0);
`endif
    tick(); reset = 1'b1; tick();
    chk("rst2_ex_mem", 32'(ex_mem), 0);
    res(1, 32'h600, 32'h0); tick(); idle();
    chk("rst2_no_feedback", 32'(ex_mem), 0);
    chk("rst2_undf_empty", 32'(undf), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
